mem_responder: RTL

Memory-side responder for the wrena/rdena/address/data bus driven by the team's bus initiators. It accepts write and read strobes with independent write and read addresses and holds a pDEPTH×pW storage array. It returns read data with a fixed, parameterised latency on an ena/dat pair that connects directly to an initiator's data-return inputs. All activity is qualified by a shared clock enable.

---
 rtl/mem_responder.sv | 74 +++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: pDEPTH x pW array with write-first read pipeline, pLAT enabled edges of latency.
// No backpressure; one write and one read accepted per enabled cycle; iclk_ena=0 freezes everything.
module mem_responder #(
  parameter int pW     = 36,
  parameter int pA     = 18,
  parameter int pDEPTH = 1024,
  parameter int pLAT   = 2
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          iclk_ena,
  input  logic          iwrena,
  input  logic          irdena,
  input  logic [pA-1:0] iwr_adr,
  input  logic [pA-1:0] ird_adr,
  input  logic [pW-1:0] idat,
  output logic          oena,
  output logic [pW-1:0] odat,
  output logic          oovf,
  input  logic          iovf_clr
);

  localparam int          cIW    = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [pA:0] cDEPTH = (pA+1)'(pDEPTH);

  logic [pW-1:0]  mem [pDEPTH];
  logic           wr_in, rd_in;
  logic [cIW-1:0] wr_idx, rd_idx;
  logic [pW-1:0]  rd_word;

  // Capture register at the accepting edge plus pLAT delay stages, so the
  // result appears after enabled edge N+pLAT for a read accepted at edge N.
  logic [pLAT:0]  vld;
  logic [pW-1:0]  dat [pLAT+1];

  always_comb begin
    wr_in   = {1'b0, iwr_adr} < cDEPTH;
    rd_in   = {1'b0, ird_adr} < cDEPTH;
    wr_idx  = wr_in ? iwr_adr[cIW-1:0] : '0;
    rd_idx  = rd_in ? ird_adr[cIW-1:0] : '0;
    rd_word = '0;
    if (rd_in) begin
      if (iwrena && wr_in && (iwr_adr == ird_adr)) rd_word = idat;
      else                                         rd_word = mem[rd_idx];
    end
  end

  // Array has no reset so its contents survive irst_n.
  always_ff @(posedge iclk) begin
    if (iclk_ena && iwrena && wr_in) mem[wr_idx] <= idat;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      vld  <= '0;
      oovf <= 1'b0;
      for (int i = 0; i <= pLAT; i++) dat[i] <= '0;
    end else if (iclk_ena) begin
      vld[0] <= irdena;
      dat[0] <= irdena ? rd_word : '0;
      for (int i = 1; i <= pLAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
      // A new out-of-range access beats a simultaneous clear.
      if ((iwrena && !wr_in) || (irdena && !rd_in)) oovf <= 1'b1;
      else if (iovf_clr)                            oovf <= 1'b0;
    end
  end

  assign oena = vld[pLAT];
  assign odat = dat[pLAT];

endmodule
